// File: rtl/writeback_queue_if.sv
// Register-file write-side bundle for writeback_queue: WB and MDU request
// channels, the registered write port and the two ID-stage forwarding ports.
interface writeback_queue_if;
  // Handshake: a request transfers on a posedge where valid && ready are both
  // high. ready depends only on queue occupancy, never on valid. A source that
  // is not accepted keeps valid, reg and data stable until it is.
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_reg;
  logic [31:0] mdu_data;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic        fwd_hit1;
  logic        fwd_hit2;
  logic [31:0] fwd_data1;
  logic [31:0] fwd_data2;

  modport slave (
    input  wb_valid, wb_reg, wb_data,
    input  mdu_valid, mdu_reg, mdu_data,
    input  read_reg1, read_reg2,
    output wb_ready, mdu_ready,
    output reg_write, write_reg, write_data,
    output fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
  );

  modport master (
    output wb_valid, wb_reg, wb_data,
    output mdu_valid, mdu_reg, mdu_data,
    output read_reg1, read_reg2,
    input  wb_ready, mdu_ready,
    input  reg_write, write_reg, write_data,
    input  fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
  );
endinterface

// File: rtl/writeback_queue.sv
// Writeback queue: merges WB and MDU results into one register-file write per
// cycle. Define WBQ_BYPASS_EN to build the read-side forwarding comparators.
module writeback_queue #(
  parameter int DEPTH = 4
) (
  input logic              clk,
  input logic              rst,
  writeback_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               reg_write_q, reg_write_d;
  logic [4:0]         write_reg_q, write_reg_d;
  logic [31:0]        write_data_q, write_data_d;

  logic wb_ready, mdu_ready;
  logic wb_push, mdu_push, pop;

  // MDU needs two free slots so a simultaneous WB push always fits.
  assign wb_ready  = (count_q < CNT_W'(DEPTH));
  assign mdu_ready = (count_q < CNT_W'(DEPTH - 1));

  assign bus.wb_ready   = wb_ready;
  assign bus.mdu_ready  = mdu_ready;
  assign bus.reg_write  = reg_write_q;
  assign bus.write_reg  = write_reg_q;
  assign bus.write_data = write_data_q;

  always_comb begin
    wb_push  = bus.wb_valid && wb_ready && (bus.wb_reg != 5'd0);
    mdu_push = bus.mdu_valid && mdu_ready && (bus.mdu_reg != 5'd0);
    pop      = (count_q != '0);

    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    // WB lands first so it is older than an MDU entry pushed in the same cycle.
    if (wb_push) begin
      mem_d[wr_ptr_q] = '{rd: bus.wb_reg, data: bus.wb_data};
    end
    if (mdu_push) begin
      mem_d[wr_ptr_q + PTR_W'(wb_push)] = '{rd: bus.mdu_reg, data: bus.mdu_data};
    end

    wr_ptr_d = wr_ptr_q + PTR_W'(wb_push) + PTR_W'(mdu_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(wb_push) + CNT_W'(mdu_push) - CNT_W'(pop);

    reg_write_d  = pop;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (pop) begin
      write_reg_d  = mem_q[rd_ptr_q].rd;
      write_data_d = mem_q[rd_ptr_q].data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= 5'd0;
      write_data_q <= 32'd0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

`ifdef WBQ_BYPASS_EN
  logic [4:0]  rd_idx [2];
  logic        hit    [2];
  logic [31:0] fdata  [2];

  assign rd_idx[0] = bus.read_reg1;
  assign rd_idx[1] = bus.read_reg2;

  // Scan oldest to youngest so the last match (youngest) wins; the output
  // register is only a fallback when no queued entry matches.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      hit[k]   = 1'b0;
      fdata[k] = 32'd0;
      if (rd_idx[k] != 5'd0) begin
        for (int i = 0; i < DEPTH; i++) begin
          if ((CNT_W'(i) < count_q) &&
              (mem_q[rd_ptr_q + PTR_W'(i)].rd == rd_idx[k])) begin
            hit[k]   = 1'b1;
            fdata[k] = mem_q[rd_ptr_q + PTR_W'(i)].data;
          end
        end
        if (!hit[k] && reg_write_q && (write_reg_q == rd_idx[k])) begin
          hit[k]   = 1'b1;
          fdata[k] = write_data_q;
        end
      end
    end
  end

  assign bus.fwd_hit1  = hit[0];
  assign bus.fwd_hit2  = hit[1];
  assign bus.fwd_data1 = fdata[0];
  assign bus.fwd_data2 = fdata[1];
`else
  assign bus.fwd_hit1  = 1'b0;
  assign bus.fwd_hit2  = 1'b0;
  assign bus.fwd_data1 = 32'd0;
  assign bus.fwd_data2 = 32'd0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: directed scenarios plus randomized traffic
// checked against a queue-based model of the write and forwarding rules.
module tb_writeback_queue;
  localparam int DEPTH = 4;
`ifdef WBQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  writeback_queue_if bus();

  writeback_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: pending writes oldest-first, plus the write port
  logic [36:0] exp_q[$];
  logic        m_rw;
  logic [4:0]  m_reg;
  logic [31:0] m_data;
  bit          last_wb_acc;
  bit          last_mdu_acc;

  function automatic bit m_wb_ready();
    return exp_q.size() < DEPTH;
  endfunction

  function automatic bit m_mdu_ready();
    return exp_q.size() < DEPTH - 1;
  endfunction

  function automatic logic [32:0] m_fwd(input logic [4:0] rr);
    if (!BYP || rr == 5'd0) return 33'd0;
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i][36:32] == rr) return {1'b1, exp_q[i][31:0]};
    end
    if (m_rw && m_reg == rr) return {1'b1, m_data};
    return 33'd0;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_rw   = 1'b0;
    m_reg  = 5'd0;
    m_data = 32'd0;
  endtask

  // advance one clock edge, updating the model with the sampled request
  task automatic tick();
    bit wa, ma;
    logic [4:0]  wr, mr;
    logic [31:0] wd, md;
    wa = bus.wb_valid && m_wb_ready();
    ma = bus.mdu_valid && m_mdu_ready();
    wr = bus.wb_reg;  wd = bus.wb_data;
    mr = bus.mdu_reg; md = bus.mdu_data;
    @(posedge clk);
    if (exp_q.size() > 0) begin
      {m_reg, m_data} = exp_q.pop_front();
      m_rw = 1'b1;
    end else begin
      m_rw = 1'b0;
    end
    if (wa && wr != 5'd0) exp_q.push_back({wr, wd});
    if (ma && mr != 5'd0) exp_q.push_back({mr, md});
    last_wb_acc  = wa;
    last_mdu_acc = ma;
    #1;
  endtask

  // driver tasks
  task automatic drive_wb(input logic v, input logic [4:0] r, input logic [31:0] d);
    bus.wb_valid = v; bus.wb_reg = r; bus.wb_data = d;
  endtask

  task automatic drive_mdu(input logic v, input logic [4:0] r, input logic [31:0] d);
    bus.mdu_valid = v; bus.mdu_reg = r; bus.mdu_data = d;
  endtask

  task automatic drain();
    drive_wb(1'b0, 5'd0, 32'd0);
    drive_mdu(1'b0, 5'd0, 32'd0);
    repeat (DEPTH + 2) tick();
  endtask

  task automatic test_reset();
    bus.read_reg1 = 5'd5;
    bus.read_reg2 = 5'd0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (bus.wb_ready !== 1'b1) begin n_bad++; $display("FAIL reset_wb_ready got=%b exp=1", bus.wb_ready); end
    n_cmp++; if (bus.mdu_ready !== 1'b1) begin n_bad++; $display("FAIL reset_mdu_ready got=%b exp=1", bus.mdu_ready); end
    n_cmp++; if (bus.reg_write !== 1'b0) begin n_bad++; $display("FAIL reset_reg_write got=%b exp=0", bus.reg_write); end
    n_cmp++; if (bus.write_reg !== 5'd0) begin n_bad++; $display("FAIL reset_write_reg got=%0d exp=0", bus.write_reg); end
    n_cmp++; if (bus.write_data !== 32'd0) begin n_bad++; $display("FAIL reset_write_data got=%h exp=0", bus.write_data); end
    n_cmp++; if (bus.fwd_hit1 !== 1'b0 || bus.fwd_data1 !== 32'd0) begin n_bad++; $display("FAIL reset_fwd1 got=%b/%h exp=0/0", bus.fwd_hit1, bus.fwd_data1); end
    n_cmp++; if (bus.fwd_hit2 !== 1'b0 || bus.fwd_data2 !== 32'd0) begin n_bad++; $display("FAIL reset_fwd2 got=%b/%h exp=0/0", bus.fwd_hit2, bus.fwd_data2); end
  endtask

  task automatic test_single_write();
    drive_wb(1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    n_cmp++; if (bus.wb_ready !== 1'b1) begin n_bad++; $display("FAIL single_ready got=%b exp=1", bus.wb_ready); end
    tick();
    drive_wb(1'b0, 5'd0, 32'd0);
    #1;
    n_cmp++; if (bus.reg_write !== 1'b0) begin n_bad++; $display("FAIL single_early got=%b exp=0", bus.reg_write); end
    tick();
    n_cmp++; if (bus.reg_write !== 1'b1 || bus.write_reg !== 5'd5 || bus.write_data !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL single_write got=%b/%0d/%h exp=1/5/deadbeef", bus.reg_write, bus.write_reg, bus.write_data);
    end
    tick();
    n_cmp++; if (bus.reg_write !== 1'b0 || bus.write_reg !== 5'd5 || bus.write_data !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL single_hold got=%b/%0d/%h exp=0/5/deadbeef", bus.reg_write, bus.write_reg, bus.write_data);
    end
  endtask

  task automatic test_dual_enqueue();
    bus.read_reg1 = 5'd3;
    bus.read_reg2 = 5'd9;
    drive_wb(1'b1, 5'd3, 32'h11);
    drive_mdu(1'b1, 5'd3, 32'h22);
    #1;
    n_cmp++; if (bus.wb_ready !== 1'b1 || bus.mdu_ready !== 1'b1) begin n_bad++; $display("FAIL dual_ready got=%b%b exp=11", bus.wb_ready, bus.mdu_ready); end
    tick();
    drive_wb(1'b0, 5'd0, 32'd0);
    drive_mdu(1'b0, 5'd0, 32'd0);
    #1;
    n_cmp++; if (bus.fwd_hit1 !== BYP || bus.fwd_data1 !== (BYP ? 32'h22 : 32'h0)) begin
      n_bad++; $display("FAIL dual_fwd_pending got=%b/%h exp=%b/%h", bus.fwd_hit1, bus.fwd_data1, BYP, BYP ? 32'h22 : 32'h0);
    end
    n_cmp++; if (bus.fwd_hit2 !== 1'b0) begin n_bad++; $display("FAIL dual_fwd2_miss got=%b exp=0", bus.fwd_hit2); end
    tick();
    n_cmp++; if (bus.reg_write !== 1'b1 || bus.write_reg !== 5'd3 || bus.write_data !== 32'h11) begin
      n_bad++; $display("FAIL dual_first got=%b/%0d/%h exp=1/3/11", bus.reg_write, bus.write_reg, bus.write_data);
    end
    n_cmp++; if (bus.fwd_hit1 !== BYP || bus.fwd_data1 !== (BYP ? 32'h22 : 32'h0)) begin
      n_bad++; $display("FAIL dual_fwd_young got=%b/%h exp=%b/%h", bus.fwd_hit1, bus.fwd_data1, BYP, BYP ? 32'h22 : 32'h0);
    end
    tick();
    n_cmp++; if (bus.reg_write !== 1'b1 || bus.write_reg !== 5'd3 || bus.write_data !== 32'h22) begin
      n_bad++; $display("FAIL dual_second got=%b/%0d/%h exp=1/3/22", bus.reg_write, bus.write_reg, bus.write_data);
    end
    n_cmp++; if (bus.fwd_hit1 !== BYP || bus.fwd_data1 !== (BYP ? 32'h22 : 32'h0)) begin
      n_bad++; $display("FAIL dual_fwd_outreg got=%b/%h exp=%b/%h", bus.fwd_hit1, bus.fwd_data1, BYP, BYP ? 32'h22 : 32'h0);
    end
    tick();
    n_cmp++; if (bus.reg_write !== 1'b0 || bus.fwd_hit1 !== 1'b0) begin
      n_bad++; $display("FAIL dual_idle got=%b/%b exp=0/0", bus.reg_write, bus.fwd_hit1);
    end
  endtask

  task automatic test_reg_zero();
    bus.read_reg1 = 5'd0;
    drive_wb(1'b1, 5'd0, 32'hFFFFFFFF);
    #1;
    n_cmp++; if (bus.wb_ready !== 1'b1) begin n_bad++; $display("FAIL zero_ready got=%b exp=1", bus.wb_ready); end
    n_cmp++; if (bus.fwd_hit1 !== 1'b0) begin n_bad++; $display("FAIL zero_fwd got=%b exp=0", bus.fwd_hit1); end
    tick();
    drive_wb(1'b0, 5'd0, 32'd0);
    tick();
    n_cmp++; if (bus.reg_write !== 1'b0 || bus.write_reg !== 5'd3 || bus.write_data !== 32'h22) begin
      n_bad++; $display("FAIL zero_no_write got=%b/%0d/%h exp=0/3/22", bus.reg_write, bus.write_reg, bus.write_data);
    end
  endtask

  task automatic test_full();
    int wb_n = 0, mdu_n = 0;
    bit saw_mdu_block = 1'b0;
    bus.read_reg1 = 5'd1;
    bus.read_reg2 = 5'd17;
    drive_wb(1'b1, 5'd1, $urandom);
    drive_mdu(1'b1, 5'd17, $urandom);
    for (int c = 0; c < 12; c++) begin
      #1;
      n_cmp++; if (bus.wb_ready !== m_wb_ready() || bus.mdu_ready !== m_mdu_ready()) begin
        n_bad++; $display("FAIL full_ready c=%0d got=%b%b exp=%b%b", c, bus.wb_ready, bus.mdu_ready, m_wb_ready(), m_mdu_ready());
      end
      if (exp_q.size() == DEPTH - 1 && bus.mdu_ready === 1'b0 && bus.wb_ready === 1'b1) saw_mdu_block = 1'b1;
      tick();
      n_cmp++; if (bus.reg_write !== m_rw || bus.write_reg !== m_reg || bus.write_data !== m_data) begin
        n_bad++; $display("FAIL full_port c=%0d got=%b/%0d/%h exp=%b/%0d/%h", c, bus.reg_write, bus.write_reg, bus.write_data, m_rw, m_reg, m_data);
      end
      if (last_wb_acc) begin wb_n++; drive_wb(1'b1, 5'(1 + wb_n % 15), $urandom); end
      if (last_mdu_acc) begin mdu_n++; drive_mdu(1'b1, 5'(16 + mdu_n % 15), $urandom); end
    end
    n_cmp++; if (saw_mdu_block !== 1'b1) begin n_bad++; $display("FAIL full_mdu_block got=%b exp=1", saw_mdu_block); end
    drive_wb(1'b0, 5'd0, 32'd0);
    drive_mdu(1'b0, 5'd0, 32'd0);
    for (int c = 0; c < DEPTH + 2; c++) begin
      tick();
      n_cmp++; if (bus.reg_write !== m_rw || bus.write_reg !== m_reg || bus.write_data !== m_data) begin
        n_bad++; $display("FAIL full_drain c=%0d got=%b/%0d/%h exp=%b/%0d/%h", c, bus.reg_write, bus.write_reg, bus.write_data, m_rw, m_reg, m_data);
      end
    end
  endtask

  task automatic test_reset_mid();
    bus.read_reg1 = 5'd12;
    drive_wb(1'b1, 5'd10, 32'hA1);
    drive_mdu(1'b1, 5'd11, 32'hA2);
    tick();
    drive_wb(1'b1, 5'd12, 32'hA3);
    drive_mdu(1'b1, 5'd13, 32'hA4);
    tick();
    drive_wb(1'b0, 5'd0, 32'd0);
    drive_mdu(1'b0, 5'd0, 32'd0);
    #1;
    n_cmp++; if (bus.reg_write !== 1'b1 || bus.write_data !== 32'hA1 || exp_q.size() != 3) begin
      n_bad++; $display("FAIL mid_prefill got=%b/%h exp=1/a1", bus.reg_write, bus.write_data);
    end
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    n_cmp++; if (bus.reg_write !== 1'b0 || bus.write_reg !== 5'd0 || bus.write_data !== 32'd0) begin
      n_bad++; $display("FAIL mid_port got=%b/%0d/%h exp=0/0/0", bus.reg_write, bus.write_reg, bus.write_data);
    end
    n_cmp++; if (bus.wb_ready !== 1'b1 || bus.mdu_ready !== 1'b1 || bus.fwd_hit1 !== 1'b0) begin
      n_bad++; $display("FAIL mid_empty got=%b%b%b exp=110", bus.wb_ready, bus.mdu_ready, bus.fwd_hit1);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < DEPTH; c++) begin
      tick();
      n_cmp++; if (bus.reg_write !== 1'b0) begin n_bad++; $display("FAIL mid_after c=%0d got=%b exp=0", c, bus.reg_write); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if (!(bus.wb_valid && !last_wb_acc))
        drive_wb($urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom);
      if (!(bus.mdu_valid && !last_mdu_acc))
        drive_mdu($urandom_range(0, 99) < 50, 5'($urandom_range(0, 7)), $urandom);
      bus.read_reg1 = 5'($urandom_range(0, 7));
      bus.read_reg2 = 5'($urandom_range(0, 7));
      #1;
      n_cmp++; if (bus.wb_ready !== m_wb_ready() || bus.mdu_ready !== m_mdu_ready()) begin
        n_bad++; $display("FAIL rand_ready c=%0d got=%b%b exp=%b%b", c, bus.wb_ready, bus.mdu_ready, m_wb_ready(), m_mdu_ready());
      end
      n_cmp++; if ({bus.fwd_hit1, bus.fwd_data1} !== m_fwd(bus.read_reg1)) begin
        n_bad++; $display("FAIL rand_fwd1 c=%0d r=%0d got=%b/%h exp=%h", c, bus.read_reg1, bus.fwd_hit1, bus.fwd_data1, m_fwd(bus.read_reg1));
      end
      n_cmp++; if ({bus.fwd_hit2, bus.fwd_data2} !== m_fwd(bus.read_reg2)) begin
        n_bad++; $display("FAIL rand_fwd2 c=%0d r=%0d got=%b/%h exp=%h", c, bus.read_reg2, bus.fwd_hit2, bus.fwd_data2, m_fwd(bus.read_reg2));
      end
      tick();
      n_cmp++; if (bus.reg_write !== m_rw || bus.write_reg !== m_reg || bus.write_data !== m_data) begin
        n_bad++; $display("FAIL rand_port c=%0d got=%b/%0d/%h exp=%b/%0d/%h", c, bus.reg_write, bus.write_reg, bus.write_data, m_rw, m_reg, m_data);
      end
    end
    drain();
    n_cmp++; if (bus.reg_write !== 1'b0 || exp_q.size() != 0) begin
      n_bad++; $display("FAIL rand_drained got=%b exp=0", bus.reg_write);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive_wb(1'b0, 5'd0, 32'd0);
    drive_mdu(1'b0, 5'd0, 32'd0);
    bus.read_reg1 = 5'd0;
    bus.read_reg2 = 5'd0;
    last_wb_acc  = 1'b0;
    last_mdu_acc = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    test_reset();
    test_single_write();
    drain();
    test_dual_enqueue();
    test_reg_zero();
    drain();
    test_full();
    drain();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
